// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit packed-BCD up/down counter with parallel load, wrap or
//   saturate at the all-9/all-0 boundaries, sticky overflow flag,
//   terminal-count strobe and a snapshot (capture) register.
//
// Parameters
//   DIGITS   number of BCD digits (1..8), digit 0 at bits [3:0]
//   SATURATE 0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports
//   CLK      rising-edge clock
//   CLR      synchronous active-high clear of all state
//   EN       count enable, one step per edge
//   UP       direction, 1 = increment, 0 = decrement
//   LD       parallel load strobe (beats EN)
//   LD_VAL   load value, packed BCD, nibbles above 9 clamp to 9
//   CAP      capture strobe, snapshots the pre-update count
//   BCD      current count (registered)
//   CAP_BCD  captured count (registered)
//   OVF      sticky boundary-crossing flag (registered)
//   TC       terminal count, combinational from state, EN and UP
//   ZERO     count is all zeros, combinational from state
module bcd_updown_counter #(
    parameter int unsigned DIGITS   = 6,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   LD_VAL,
    input  logic                  CAP,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [4*DIGITS-1:0]   CAP_BCD,
    output logic                  OVF,
    output logic                  TC,
    output logic                  ZERO
);

    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] cap_reg;
    logic                ovf_reg;

    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] clamped;
    logic                all_nine;
    logic                all_zero;
    logic                carry;
    logic [3:0]          digit;

    // Ripple carry/borrow: a digit only moves while every lower digit is at
    // its wrap value (9 going up, 0 going down). The carry left over after
    // the top digit means the whole count crossed a boundary.
    always_comb begin
        stepped  = count;
        carry    = 1'b1;
        digit    = '0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (digit != 4'd9) all_nine = 1'b0;
            if (digit != 4'd0) all_zero = 1'b0;
            if (carry) begin
                if (UP) begin
                    stepped[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                    carry             = (digit == 4'd9);
                end else begin
                    stepped[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                    carry             = (digit == 4'd0);
                end
            end
        end
    end

    always_comb begin
        clamped = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            clamped[4*i +: 4] = (LD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : LD_VAL[4*i +: 4];
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            count   <= '0;
            cap_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            // Capture sees the count before any load/step on this edge.
            if (CAP) cap_reg <= count;
            if (LD) begin
                count   <= clamped;
                ovf_reg <= 1'b0;
            end else if (EN) begin
                if (carry) ovf_reg <= 1'b1;
                if (!(carry && SATURATE)) count <= stepped;
            end
        end
    end

    assign BCD     = count;
    assign CAP_BCD = cap_reg;
    assign OVF     = ovf_reg;
    assign TC      = EN & ((UP & all_nine) | (~UP & all_zero));
    assign ZERO    = all_zero;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter
//   Directed-vector bench for bcd_updown_counter. Three instances:
//   index 0 = 6 digits wrap, 1 = 6 digits saturate, 2 = 2 digits wrap.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr    [3];
    logic        en     [3];
    logic        up     [3];
    logic        ld     [3];
    logic        cap    [3];
    logic [23:0] ld_val [3];

    logic [23:0] bcd_w, cap_w, bcd_s, cap_s;
    logic [7:0]  bcd_t, cap_t;
    logic        ovf_w, tc_w, zero_w;
    logic        ovf_s, tc_s, zero_s;
    logic        ovf_t, tc_t, zero_t;

    int unsigned total = 0;
    int unsigned bad   = 0;

    bcd_updown_counter #(.DIGITS(6), .SATURATE(1'b0)) u_wrap (
        .CLK(clk), .CLR(clr[0]), .EN(en[0]), .UP(up[0]), .LD(ld[0]),
        .LD_VAL(ld_val[0]), .CAP(cap[0]), .BCD(bcd_w), .CAP_BCD(cap_w),
        .OVF(ovf_w), .TC(tc_w), .ZERO(zero_w)
    );

    bcd_updown_counter #(.DIGITS(6), .SATURATE(1'b1)) u_sat (
        .CLK(clk), .CLR(clr[1]), .EN(en[1]), .UP(up[1]), .LD(ld[1]),
        .LD_VAL(ld_val[1]), .CAP(cap[1]), .BCD(bcd_s), .CAP_BCD(cap_s),
        .OVF(ovf_s), .TC(tc_s), .ZERO(zero_s)
    );

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u_two (
        .CLK(clk), .CLR(clr[2]), .EN(en[2]), .UP(up[2]), .LD(ld[2]),
        .LD_VAL(ld_val[2][7:0]), .CAP(cap[2]), .BCD(bcd_t), .CAP_BCD(cap_t),
        .OVF(ovf_t), .TC(tc_t), .ZERO(zero_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int k, input logic [23:0] v);
        ld[k]     = 1'b1;
        ld_val[k] = v;
        tick();
        ld[k]     = 1'b0;
    endtask

    function automatic logic [23:0] to_bcd(input int n);
        logic [23:0] r;
        int          m;
        m = n;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m           = m / 10;
        end
        return r;
    endfunction

    initial begin
        int          exp_n;
        int          tc_seen;
        logic [23:0] dn_seq [7];

        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b1; en[k] = 1'b0; up[k] = 1'b1;
            ld[k] = 1'b0; cap[k] = 1'b0; ld_val[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) clr[k] = 1'b0;

        // Reset state
        check("rst_bcd",  32'(bcd_w),  32'h0);
        check("rst_cap",  32'(cap_w),  32'h0);
        check("rst_ovf",  32'(ovf_w),  32'h0);
        check("rst_zero", 32'(zero_w), 32'h1);
        en[0] = 1'b1; up[0] = 1'b0; #1;
        check("rst_tc_down", 32'(tc_w), 32'h1);
        up[0] = 1'b1; #1;
        check("rst_tc_up", 32'(tc_w), 32'h0);
        en[0] = 1'b0;
        tick();

        // Count up through the top boundary in wrap mode
        do_load(0, 24'h999990);
        check("ld_999990", 32'(bcd_w), 32'h999990);
        en[0] = 1'b1; up[0] = 1'b1;
        exp_n = 999990;
        tc_seen = 0;
        for (int i = 0; i < 133; i++) begin
            #1;
            check("tc_up", 32'(tc_w), 32'(exp_n == 999999));
            if (tc_w) tc_seen++;
            tick();
            exp_n = (exp_n + 1) % 1000000;
        end
        en[0] = 1'b0;
        check("up_bcd_model", 32'(bcd_w), 32'(to_bcd(exp_n)));
        check("up_bcd_123",   32'(bcd_w), 32'h000123);
        check("up_ovf",       32'(ovf_w), 32'h1);
        check("up_tc_count",  32'(tc_seen), 32'd1);

        // Hold with EN low
        tick();
        check("hold_bcd", 32'(bcd_w), 32'h000123);

        // Load 5, count down through zero
        do_load(0, 24'h000005);
        check("ld5_bcd",  32'(bcd_w), 32'h000005);
        check("ld5_ovf",  32'(ovf_w), 32'h0);
        check("ld5_zero", 32'(zero_w), 32'h0);
        dn_seq = '{24'h000004, 24'h000003, 24'h000002, 24'h000001,
                   24'h000000, 24'h999999, 24'h999998};
        en[0] = 1'b1; up[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("dn_bcd",  32'(bcd_w),  32'(dn_seq[i]));
            check("dn_ovf",  32'(ovf_w),  32'(i >= 5));
            check("dn_zero", 32'(zero_w), 32'(i == 4));
        end
        en[0] = 1'b0;

        // Clamp of invalid nibbles; load clears OVF
        do_load(0, 24'h00A9F3);
        check("clamp_bcd", 32'(bcd_w), 32'h009993);
        check("clamp_ovf", 32'(ovf_w), 32'h0);

        // Capture with load and enable on the same edge
        do_load(0, 24'h000042);
        cap[0] = 1'b1; ld[0] = 1'b1; en[0] = 1'b1; up[0] = 1'b1;
        ld_val[0] = 24'h000100;
        tick();
        check("cap_val", 32'(cap_w), 32'h000042);
        check("cap_ld",  32'(bcd_w), 32'h000100);
        ld[0] = 1'b0;
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0; cap[0] = 1'b0; en[0] = 1'b0;
        check("clr_bcd", 32'(bcd_w), 32'h0);
        check("clr_cap", 32'(cap_w), 32'h0);
        check("clr_ovf", 32'(ovf_w), 32'h0);

        // Saturate mode: top boundary
        do_load(1, 24'h999998);
        en[1] = 1'b1; up[1] = 1'b1;
        tick();
        check("sat_up1",     32'(bcd_s), 32'h999999);
        check("sat_up1_ovf", 32'(ovf_s), 32'h0);
        #1;
        check("sat_tc", 32'(tc_s), 32'h1);
        tick();
        check("sat_up2",     32'(bcd_s), 32'h999999);
        check("sat_up2_ovf", 32'(ovf_s), 32'h1);
        tick();
        check("sat_up3", 32'(bcd_s), 32'h999999);
        up[1] = 1'b0;
        tick();
        check("sat_dn",     32'(bcd_s), 32'h999998);
        check("sat_dn_ovf", 32'(ovf_s), 32'h1);
        en[1] = 1'b0;

        // Saturate mode: bottom boundary
        do_load(1, 24'h000000);
        check("sat_ld0_ovf", 32'(ovf_s), 32'h0);
        en[1] = 1'b1; up[1] = 1'b0;
        tick();
        en[1] = 1'b0;
        check("sat_lo_bcd", 32'(bcd_s), 32'h000000);
        check("sat_lo_ovf", 32'(ovf_s), 32'h1);
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        check("sat_clr_ovf", 32'(ovf_s), 32'h0);

        // Two-digit wrap instance
        do_load(2, 24'h000098);
        en[2] = 1'b1; up[2] = 1'b1;
        tick();
        check("two_99",     32'(bcd_t), 32'h99);
        check("two_99_ovf", 32'(ovf_t), 32'h0);
        tick();
        check("two_00",     32'(bcd_t), 32'h00);
        check("two_00_ovf", 32'(ovf_t), 32'h1);
        up[2] = 1'b0;
        tick();
        check("two_dn99",     32'(bcd_t), 32'h99);
        check("two_dn99_ovf", 32'(ovf_t), 32'h1);
        en[2] = 1'b0;
        do_load(2, 24'h0000FA);
        check("two_clamp", 32'(bcd_t), 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter for the reaction-timer datapath, generalising the fixed six-digit up-counter. Adds configurable digit count, up/down direction, parallel load, wrap or saturate mode, a sticky overflow flag, a terminal-count strobe and a capture register for lap/best-time snapshots. It sits between the timebase enable generator and the seven-segment/score logic.

## Interface
- DIGITS, 6, number of BCD digits (1..8); digit 0 is least significant, at bits [3:0].
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.
- CLK  input  1  rising-edge clock; the only clock.
- CLR  input  1  reset; synchronous, active-high; clears all state.
- EN  input  1  count enable, one step per CLK edge while high.
- UP  input  1  direction: 1 = increment, 0 = decrement; sampled with EN.
- LD  input  1  parallel load strobe.
- LD_VAL  input  4*DIGITS  load value, packed BCD.
- CAP  input  1  capture strobe.
- BCD  output  4*DIGITS  current count, packed BCD, registered.
- CAP_BCD  output  4*DIGITS  captured count, registered.
- OVF  output  1  sticky boundary-crossing flag, registered.
- TC  output  1  terminal count, combinational from registered state, EN and UP.
- ZERO  output  1  high when BCD is all zeros, combinational from registered state.

## Operation
- Update priority per edge: CLR > LD > EN. CAP is evaluated independently of LD and EN.
- CLR=1: BCD, CAP_BCD and OVF become 0. LD, EN and CAP are ignored.
- LD=1 (CLR=0): BCD <= LD_VAL, with each nibble greater than 9 clamped to 9. OVF is cleared. EN is ignored that cycle.
- EN=1, UP=1: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. This ripples across all DIGITS within one cycle.
- EN=1, UP=0: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Upper boundary: all digits are 9 and UP=1 with EN=1.
  - SATURATE=0: BCD becomes all zeros.
  - SATURATE=1: BCD holds.
  - In both modes, OVF is set.
- Lower boundary: all digits are 0 and UP=0 with EN=1.
  - SATURATE=0: BCD becomes all nines.
  - SATURATE=1: BCD holds.
  - In both modes, OVF is set.
- OVF stays set until CLR or LD. It is not set by a load to a boundary value.
- TC = EN & ((UP & BCD all-9) | (~UP & BCD all-0)). It marks the cycle whose edge crosses or hits the boundary.
- ZERO = (BCD == 0).
- CAP=1 (CLR=0): CAP_BCD <= BCD value before this edge's update. This includes the pre-load value when LD=1 in the same cycle. Otherwise CAP_BCD holds.
- EN=0, LD=0, CLR=0: BCD holds.
- A change of UP between cycles takes effect on the next enabled edge. There is no pipeline state.

## Timing
- Reset values: BCD = 0, CAP_BCD = 0, OVF = 0. Consequently ZERO = 1 and TC = EN & ~UP after CLR.
- Latency:
  - EN, LD and CAP take effect at the next rising CLK, and outputs are visible one cycle later.
  - TC and ZERO are zero-latency functions of current state and inputs.
- CLR asserted mid-count takes effect at the next edge regardless of other inputs. There is no asynchronous path.
- Carry/borrow chain is combinational across DIGITS. It must close timing at the design clock for DIGITS=8.
- No handshake. EN may be a one-cycle pulse train or held high continuously.

## Test plan
- CLR, then EN=1, UP=1 for 1,000,123 cycles, DIGITS=6, SATURATE=0 -> BCD=000123 and OVF=1. TC pulses once, in the cycle with BCD=999999.
- LD with LD_VAL=0x000005, then UP=0 for 7 enabled cycles, SATURATE=0 -> sequence 5,4,3,2,1,0,999999,999998. OVF set on the 0->999999 edge. ZERO high only while BCD=0.
- SATURATE=1, load 999998, then UP=1 for 3 cycles -> 999999,999999,999999. OVF=1 after the second edge. A following UP=0 cycle gives 999998.
- Load LD_VAL=0x00A9F3 -> BCD=0x009993 (invalid nibbles clamped to 9). OVF is cleared by the same load.
- With BCD=000042, assert CAP, LD (LD_VAL=000100) and EN together -> CAP_BCD=000042 and BCD=000100. Next cycle with CLR, CAP and EN all high -> BCD=0, CAP_BCD=0, OVF=0.
- DIGITS=2: from 98, apply UP=1 for 2 cycles -> 99 then 00 with OVF=1. Then UP=0 for 1 cycle -> 99, OVF still 1.
